// File: rtl/mem_responder.sv
// Single-port main-memory model with an open-row latency model: a row hit answers in HIT_LATENCY cycles, a miss in MISS_LATENCY.
// Optional build macro MEM_PROTOCOL_CHECK_EN adds a sticky proto_err output for initiator handshake violations.
module mem_responder #(
    parameter int ADDR_WIDTH   = 64,
    parameter int WORD_WIDTH   = 64,
    parameter int DEPTH_BITS   = 10,
    parameter int COL_BITS     = 3,
    parameter int HIT_LATENCY  = 2,
    parameter int MISS_LATENCY = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] din,
    output logic [WORD_WIDTH-1:0] dout,
    input  logic                  re,
    input  logic                  we,
    output logic                  ready
`ifdef MEM_PROTOCOL_CHECK_EN
    ,
    output logic                  proto_err
`endif
);

    localparam int ROW_BITS = DEPTH_BITS - COL_BITS;
    localparam logic [7:0] HIT_M1  = 8'(HIT_LATENCY - 1);
    localparam logic [7:0] MISS_M1 = 8'(MISS_LATENCY - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state_q, state_d;
    logic [7:0]              lat_cnt_q, lat_cnt_d;
    logic [DEPTH_BITS-1:0]   cap_addr_q, cap_addr_d;
    logic [WORD_WIDTH-1:0]   cap_din_q, cap_din_d;
    logic                    cap_rd_q, cap_rd_d;
    logic [ROW_BITS-1:0]     open_row_q, open_row_d;
    logic                    row_valid_q, row_valid_d;
    logic [WORD_WIDTH-1:0]   dout_q;
    logic                    mem_we, mem_re;

    logic [WORD_WIDTH-1:0]   mem_q [0:(2**DEPTH_BITS)-1];

    // Upper address bits are deliberately dropped so the array aliases.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[ADDR_WIDTH-1:DEPTH_BITS];

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        cap_addr_d  = cap_addr_q;
        cap_din_d   = cap_din_q;
        cap_rd_d    = cap_rd_q;
        open_row_d  = open_row_q;
        row_valid_d = row_valid_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        ready       = (state_q == IDLE);
        case (state_q)
            IDLE: begin
                if (re || we) begin
                    cap_addr_d = addr[DEPTH_BITS-1:0];
                    cap_din_d  = din;
                    cap_rd_d   = re;
                    lat_cnt_d  = (row_valid_q && addr[DEPTH_BITS-1:COL_BITS] == open_row_q)
                                 ? HIT_M1 : MISS_M1;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (lat_cnt_q == 8'd0) begin
                    mem_re      = cap_rd_q;
                    mem_we      = !cap_rd_q;
                    open_row_d  = cap_addr_q[DEPTH_BITS-1:COL_BITS];
                    row_valid_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_cnt_q   <= 8'd0;
            cap_addr_q  <= '0;
            cap_din_q   <= '0;
            cap_rd_q    <= 1'b0;
            open_row_q  <= '0;
            row_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            cap_addr_q  <= cap_addr_d;
            cap_din_q   <= cap_din_d;
            cap_rd_q    <= cap_rd_d;
            open_row_q  <= open_row_d;
            row_valid_q <= row_valid_d;
        end
    end

    // Array is never reset; a write landing on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[cap_addr_q] <= cap_din_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (mem_re) begin
            dout_q <= mem_q[cap_addr_q];
        end
    end

    assign dout = dout_q;

`ifdef MEM_PROTOCOL_CHECK_EN
    logic prev_req_q;
    logic proto_err_q;
    logic viol_both, viol_busy, viol_consec;

    assign viol_both   = re && we;
    assign viol_busy   = (re || we) && !ready;
    assign viol_consec = (re || we) && prev_req_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_req_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            prev_req_q <= re || we;
            if (viol_both || viol_busy || viol_consec) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign proto_err = proto_err_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (viol_both)   $display("%0t mem_responder: protocol violation: re and we both high", $time);
            if (viol_busy)   $display("%0t mem_responder: protocol violation: request while busy", $time);
            if (viol_consec) $display("%0t mem_responder: protocol violation: request on consecutive cycles", $time);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: expected latency and dout are queued at issue and
// checked when ready returns high.
module tb_mem_responder;

    localparam int AW = 64;
    localparam int WW = 64;
    localparam int DB = 10;
    localparam int CB = 3;
    localparam int HIT_L = 2;
    localparam int MISS_L = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [WW-1:0] din = '0;
    logic [WW-1:0] dout;
    logic          re = 1'b0;
    logic          we = 1'b0;
    logic          ready;
`ifdef MEM_PROTOCOL_CHECK_EN
    logic          proto_err;
`endif

    mem_responder #(
        .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .DEPTH_BITS(DB), .COL_BITS(CB),
        .HIT_LATENCY(HIT_L), .MISS_LATENCY(MISS_L)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout),
        .re(re), .we(we), .ready(ready)
`ifdef MEM_PROTOCOL_CHECK_EN
        , .proto_err(proto_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          lat;
        logic [63:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference state: array contents, open row and the value dout should hold.
    logic [63:0] model_mem [0:(2**DB)-1];
    logic [DB-CB-1:0] model_row = '0;
    logic        model_row_valid = 1'b0;
    logic [63:0] model_dout = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with ready=1; returns at the negedge where ready is back high.
    task automatic issue(input logic r, input logic w, input logic [63:0] a, input logic [63:0] d,
                         input string tag, input bit inject);
        exp_t e;
        int   cnt;
        logic [DB-1:0] idx;
        logic [DB-CB-1:0] row;
        idx = a[DB-1:0];
        row = idx[DB-1:CB];
        e.tag = tag;
        e.lat = (model_row_valid && row == model_row) ? HIT_L : MISS_L;
        if (r) begin
            model_dout = model_mem[idx];
        end else begin
            model_mem[idx] = d;
        end
        e.data = model_dout;
        model_row = row;
        model_row_valid = 1'b1;
        sb.push_back(e);

        re = r; we = w; addr = a; din = d;
        @(negedge clk);
        re = 1'b0; we = 1'b0;
        cnt = 0;
        while (ready == 1'b0 && cnt < 300) begin
            cnt++;
            if (inject && cnt == 2) begin
                re = 1'b1; addr = 64'd3;
            end
            @(negedge clk);
            re = 1'b0;
        end
        e = sb.pop_front();
        check({e.tag, "_lat"}, 64'(cnt), 64'(e.lat));
        check({e.tag, "_dout"}, dout, e.data);
        $display("txn %s r=%0b w=%0b addr=%0h lat=%0d dout=%0h", e.tag, r, w, a, cnt, dout);
    endtask

    initial begin
        for (int i = 0; i < 2**DB; i++) model_mem[i] = '0;

        // 1: reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_dout", dout, 64'd0);
        issue(1'b1, 1'b0, 64'd5, 64'd0, "rd5", 1'b0);

        // 2: row hit / miss
        issue(1'b0, 1'b1, 64'h10, 64'hA5, "wr10", 1'b0);
        issue(1'b1, 1'b0, 64'h11, 64'd0, "rd11", 1'b0);
        issue(1'b1, 1'b0, 64'h10, 64'd0, "rd10", 1'b0);
        issue(1'b1, 1'b0, 64'h40, 64'd0, "rd40", 1'b0);

        // 3: back-to-back writes then reads
        for (int i = 0; i < 8; i++) issue(1'b0, 1'b1, 64'(i), 64'(i + 1), $sformatf("b2b_wr%0d", i), 1'b0);
        for (int i = 0; i < 8; i++) issue(1'b1, 1'b0, 64'(i), 64'd0, $sformatf("b2b_rd%0d", i), 1'b0);

        // 4: request pulsed while busy must be ignored
        issue(1'b0, 1'b1, 64'h20, 64'h5A, "wr20_inj", 1'b1);
        check("no_extra_access", 64'(ready), 64'd1);
`ifdef MEM_PROTOCOL_CHECK_EN
        check("proto_err", 64'(proto_err), 64'd1);
`endif
        issue(1'b1, 1'b0, 64'h20, 64'd0, "rd20", 1'b0);

        // 5: reset two cycles into a write to addr 9
        re = 1'b0; we = 1'b1; addr = 64'd9; din = 64'h77;
        @(negedge clk);
        we = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_row_valid = 1'b0;
        model_dout = '0;
        check("midrst_ready", 64'(ready), 64'd1);
        check("midrst_dout", dout, 64'd0);
        issue(1'b1, 1'b0, 64'd9, 64'd0, "rd9_after_rst", 1'b0);

        // 6: re&we at an aliased address is a read of addr 0; array stays intact
        issue(1'b1, 1'b1, 64'h400, 64'hDEAD, "rdwr400", 1'b0);
        issue(1'b1, 1'b0, 64'd0, 64'd0, "rd0_again", 1'b0);

        if (sb.size() != 0) check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
